// File: rtl/flappy_game_core.sv
// rtl/flappy_game_core.sv - Flappy Bird rule engine: collisions, passes, IDLE/PLAY/DEAD FSM, BCD score, tone audio
// Optional high-score register built only when FLAPPY_HISCORE_EN is defined.
module flappy_game_core #(
    parameter int N_PIPES      = 3,
    parameter int PIPE_HALF_W  = 50,
    parameter int GAP_HALF     = 50,
    parameter int BIRD_HALF    = 5,
    parameter int GROUND_Y     = 514,
    parameter int SCORE_DIGITS = 4,
    parameter int PASS_DIV     = 83333,
    parameter int HIT_DIV      = 166666,
    parameter int PASS_DUR     = 5000000,
    parameter int HIT_DUR      = 20000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tick,
    input  logic                      start,
    input  logic [11:0]               bird_x,
    input  logic [11:0]               bird_y,
    input  logic [12*N_PIPES-1:0]     pipe_x,
    input  logic [12*N_PIPES-1:0]     pipe_y,
    output logic [1:0]                state,
    output logic                      fail,
    output logic [4*SCORE_DIGITS-1:0] score_bcd,
    output logic [4*SCORE_DIGITS-1:0] hiscore_bcd,
    output logic                      pass_pulse,
    output logic                      hit_pulse,
    output logic                      audio_out
);
    localparam int SW      = 4 * SCORE_DIGITS;
    localparam int DUR_MAX = (HIT_DUR > PASS_DUR) ? HIT_DUR : PASS_DUR;
    localparam int DIV_MAX = (HIT_DIV > PASS_DIV) ? HIT_DIV : PASS_DIV;
    localparam int DW      = $clog2(DUR_MAX + 1);
    localparam int TW      = $clog2(DIV_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DEAD = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [12:0]        bx, by;
    logic [N_PIPES-1:0] hit_vec, past_vec, past_q;
    logic               hit_any, pass_any;
    logic               clr_score, inc_score, hit_ev, pass_ev;

    assign bx = {1'b0, bird_x};
    assign by = {1'b0, bird_y};

    // Comparisons are arranged so every term is a sum; nothing can underflow.
    for (genvar i = 0; i < N_PIPES; i++) begin : g_pipe
        logic [12:0] px, py;
        logic        x_ovl, out_gap;
        assign px       = {1'b0, pipe_x[12*i +: 12]};
        assign py       = {1'b0, pipe_y[12*i +: 12]};
        assign x_ovl    = (bx + 13'(BIRD_HALF + PIPE_HALF_W) >= px) &&
                          (px + 13'(PIPE_HALF_W + BIRD_HALF) >= bx);
        assign out_gap  = (by + 13'(GAP_HALF) <= py + 13'(BIRD_HALF)) ||
                          (by + 13'(BIRD_HALF) >= py + 13'(GAP_HALF));
        assign hit_vec[i]  = x_ovl && out_gap;
        assign past_vec[i] = (px + 13'(PIPE_HALF_W + BIRD_HALF)) < bx;
    end

    assign hit_any  = (|hit_vec) || (by >= 13'(GROUND_Y));
    assign pass_any = |(past_vec & ~past_q);

    always_comb begin
        state_d   = state_q;
        clr_score = 1'b0;
        inc_score = 1'b0;
        hit_ev    = 1'b0;
        pass_ev   = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: if (start) begin
                    state_d   = PLAY;
                    clr_score = 1'b1;
                end
                PLAY: if (hit_any) begin
                    state_d = DEAD;
                    hit_ev  = 1'b1;
                end else if (pass_any) begin
                    inc_score = 1'b1;
                    pass_ev   = 1'b1;
                end
                DEAD: if (start) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    logic [SW-1:0] score_nxt;
    logic          carry, score_max;

    always_comb begin
        score_nxt = score_bcd;
        carry     = 1'b1;
        score_max = 1'b1;
        for (int d = 0; d < SCORE_DIGITS; d++) begin
            if (score_bcd[4*d +: 4] != 4'd9) score_max = 1'b0;
            if (carry) begin
                if (score_bcd[4*d +: 4] == 4'd9) begin
                    score_nxt[4*d +: 4] = 4'd0;
                end else begin
                    score_nxt[4*d +: 4] = score_bcd[4*d +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fail       <= 1'b0;
            score_bcd  <= '0;
            past_q     <= '0;
            pass_pulse <= 1'b0;
            hit_pulse  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fail       <= (state_d == DEAD);
            hit_pulse  <= hit_ev;
            pass_pulse <= pass_ev;
            if (tick) past_q <= past_vec;
            if (clr_score) score_bcd <= '0;
            else if (inc_score && !score_max) score_bcd <= score_nxt;
        end
    end

    assign state = state_q;

`ifdef FLAPPY_HISCORE_EN
    // For valid BCD a plain unsigned compare equals a digit-wise MSD-first compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hiscore_bcd <= '0;
        else if (hit_ev && (score_bcd > hiscore_bcd)) hiscore_bcd <= score_bcd;
    end
`else
    assign hiscore_bcd = '0;
`endif

    logic [DW-1:0] dur_cnt;
    logic [TW-1:0] tone_cnt, tone_nxt, period;
    logic          hit_mode;

    assign period   = hit_mode ? TW'(HIT_DIV) : TW'(PASS_DIV);
    assign tone_nxt = (tone_cnt == period - TW'(1)) ? '0 : tone_cnt + TW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dur_cnt   <= '0;
            tone_cnt  <= '0;
            hit_mode  <= 1'b0;
            audio_out <= 1'b0;
        end else if (hit_pulse) begin
            dur_cnt   <= DW'(HIT_DUR);
            tone_cnt  <= '0;
            hit_mode  <= 1'b1;
            audio_out <= (HIT_DIV > 1) && (HIT_DUR > 0);
        end else if (pass_pulse && !(hit_mode && dur_cnt != '0)) begin
            dur_cnt   <= DW'(PASS_DUR);
            tone_cnt  <= '0;
            hit_mode  <= 1'b0;
            audio_out <= (PASS_DIV > 1) && (PASS_DUR > 0);
        end else if (dur_cnt != '0) begin
            dur_cnt   <= dur_cnt - DW'(1);
            tone_cnt  <= tone_nxt;
            audio_out <= (dur_cnt != DW'(1)) && (tone_nxt < (period >> 1));
        end else begin
            audio_out <= 1'b0;
        end
    end
endmodule

// File: tb/tb_flappy_game_core.sv
// tb/tb_flappy_game_core.sv - self-checking bench for flappy_game_core against a behavioural game model
module tb_flappy_game_core;
    localparam int PHW = 50, GH = 50, BH = 5, GROUND = 514;
    localparam int PDIV = 8, HDIV = 12, PDUR = 30, HDUR = 60;

    logic        clk = 1'b0, rst_n = 1'b0, tick = 1'b0, start = 1'b0;
    logic [11:0] bird_x, bird_y;
    logic [35:0] pipe_x, pipe_y;
    logic [1:0]  state;
    logic        fail, pass_pulse, hit_pulse, audio_out;
    logic [15:0] score_bcd, hiscore_bcd;

    int bx = 150, by = 240;
    int px [3] = '{1000, 1000, 1000};
    int py [3] = '{240, 240, 240};
    assign bird_x = bx[11:0];
    assign bird_y = by[11:0];
    assign pipe_x = {px[2][11:0], px[1][11:0], px[0][11:0]};
    assign pipe_y = {py[2][11:0], py[1][11:0], py[0][11:0]};

    flappy_game_core #(
        .N_PIPES(3), .PIPE_HALF_W(PHW), .GAP_HALF(GH), .BIRD_HALF(BH), .GROUND_Y(GROUND),
        .SCORE_DIGITS(4), .PASS_DIV(PDIV), .HIT_DIV(HDIV), .PASS_DUR(PDUR), .HIT_DUR(HDUR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start),
        .bird_x(bird_x), .bird_y(bird_y), .pipe_x(pipe_x), .pipe_y(pipe_y),
        .state(state), .fail(fail), .score_bcd(score_bcd), .hiscore_bcd(hiscore_bcd),
        .pass_pulse(pass_pulse), .hit_pulse(hit_pulse), .audio_out(audio_out)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int m_state = 0, m_score = 0, m_hi = 0;
    bit m_past [3];
    bit e_hp, e_pp, p_hit, p_pass, ph;
    int s_left = 0, s_k = 0, s_p = PDIV;
    bit s_hit = 0;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // One clock of the sound model: check audio, then advance to the next cycle.
    task automatic cyc();
        bit exp_a, act_hit;
        @(negedge clk);
        exp_a = (s_left > 0) && ((s_k % s_p) < s_p / 2);
        total++;
        if (audio_out !== exp_a) begin
            bad++;
            $display("FAIL audio t=%0t got=%b exp=%b", $time, audio_out, exp_a);
        end
        act_hit = (s_left > 0) && s_hit;
        if (s_left > 0) begin s_left--; s_k++; end
        if (p_hit) begin
            s_left = HDUR; s_k = 0; s_p = HDIV; s_hit = 1;
        end else if (p_pass && !act_hit) begin
            s_left = PDUR; s_k = 0; s_p = PDIV; s_hit = 0;
        end
        p_hit = 0; p_pass = 0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        m_state = 0; m_score = 0; m_hi = 0;
        m_past = '{0, 0, 0};
        s_left = 0; s_k = 0; s_hit = 0; p_hit = 0; p_pass = 0;
    endtask

    // Game rules in plain distance terms; applies one tick to both model and DUT.
    task automatic step(input bit st);
        bit h, p;
        h = (by >= GROUND);
        p = 0;
        for (int i = 0; i < 3; i++) begin
            if (iabs(bx - px[i]) <= PHW + BH && iabs(by - py[i]) >= GH - BH) h = 1;
            if ((bx - px[i] > PHW + BH) && !m_past[i]) p = 1;
        end
        e_hp = 0; e_pp = 0;
        case (m_state)
            0: if (st) begin m_state = 1; m_score = 0; end
            1: if (h) begin
                m_state = 2; e_hp = 1;
`ifdef FLAPPY_HISCORE_EN
                if (m_score > m_hi) m_hi = m_score;
`endif
            end else if (p) begin
                e_pp = 1;
                if (m_score < 9999) m_score++;
            end
            default: if (st) m_state = 0;
        endcase
        for (int i = 0; i < 3; i++) m_past[i] = (bx - px[i] > PHW + BH);
        cyc();
        cyc();
        tick = 1'b1; start = st;
        @(posedge clk); #1;
        tick = 1'b0; start = 1'b0;
        p_hit = e_hp; p_pass = e_pp;
    endtask

    task automatic gain(input int n);
        for (int k = 0; k < n; k++) begin
            px[0] = ph ? 94 : 95;
            px[1] = ph ? 95 : 94;
            ph = ~ph;
            step(0);
        end
    endtask

    task automatic setup_play(input int y);
        bx = 150; by = y;
        px = '{95, 95, 1000}; py = '{240, 240, 240};
        ph = 1;
        step(1);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({state, fail, score_bcd, hiscore_bcd, pass_pulse, hit_pulse, audio_out} !== 40'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", {state, fail, score_bcd, hiscore_bcd, pass_pulse, hit_pulse, audio_out});
        end
        do_reset();
    endtask

    task automatic test_start();
        bx = 150; by = 240; px = '{1000, 1000, 1000};
        step(1);
        total++;
        if (state !== 2'b01 || fail !== 1'b0 || score_bcd !== 16'h0000 || audio_out !== 1'b0) begin
            bad++;
            $display("FAIL start state=%b fail=%b score=%h audio=%b exp 01/0/0000/0", state, fail, score_bcd, audio_out);
        end
    endtask

    task automatic test_pass();
        int npass;
        npass = 0;
        px[0] = 210; py[0] = 240;
        for (int x = 210; x >= 90; x--) begin
            px[0] = x;
            step(0);
            if (pass_pulse === 1'b1) begin
                npass++;
                total++;
                if (x != 94) begin bad++; $display("FAIL pass_position got_x=%0d exp_x=94", x); end
                cyc(); cyc();
                total++;
                if (pass_pulse !== 1'b0) begin bad++; $display("FAIL pass_pulse_width got=%b exp=0", pass_pulse); end
            end
        end
        total++;
        if (npass != 1) begin bad++; $display("FAIL pass_count got=%0d exp=1", npass); end
        total++;
        if (score_bcd !== 16'h0001) begin bad++; $display("FAIL pass_score got=%h exp=0001", score_bcd); end
        repeat (PDUR + 10) cyc();
    endtask

    task automatic test_hit();
        by = 200; px = '{1000, 150, 1000}; py = '{240, 300, 240};
        step(0);
        total++;
        if (hit_pulse !== 1'b1 || pass_pulse !== 1'b0 || state !== 2'b10 || fail !== 1'b1) begin
            bad++;
            $display("FAIL hit hit=%b pass=%b state=%b fail=%b exp 1/0/10/1", hit_pulse, pass_pulse, state, fail);
        end
        cyc(); cyc();
        total++;
        if (audio_out !== 1'b1) begin bad++; $display("FAIL hit_tone got=%b exp=1", audio_out); end
        px = '{94, 1000, 1000}; py = '{240, 240, 240}; by = 240;
        repeat (3) step(0);
        total++;
        if (score_bcd !== 16'h0001 || state !== 2'b10) begin
            bad++;
            $display("FAIL dead_hold score=%h state=%b exp 0001/10", score_bcd, state);
        end
        step(1);
        total++;
        if (state !== 2'b00 || fail !== 1'b0) begin bad++; $display("FAIL dead_to_idle state=%b fail=%b exp 00/0", state, fail); end
    endtask

    task automatic test_priority();
        do_reset();
        setup_play(240);
        px[0] = 94; px[1] = 94;
        step(0);
        total++;
        if (score_bcd !== 16'h0001 || pass_pulse !== 1'b1) begin
            bad++;
            $display("FAIL multi_pass score=%h pass=%b exp 0001/1", score_bcd, pass_pulse);
        end
        px[0] = 95; px[1] = 95;
        step(0);
        px[0] = 94; px[2] = 150; py[2] = 400;
        step(0);
        total++;
        if (state !== 2'b10 || score_bcd !== 16'h0001 || hit_pulse !== 1'b1 || pass_pulse !== 1'b0) begin
            bad++;
            $display("FAIL priority state=%b score=%h hit=%b pass=%b exp 10/0001/1/0", state, score_bcd, hit_pulse, pass_pulse);
        end
        repeat (HDUR + 5) cyc();
    endtask

    task automatic test_saturate();
        do_reset();
        setup_play(240);
        gain(199);
        total++;
        if (score_bcd !== 16'h0199) begin bad++; $display("FAIL score_0199 got=%h exp=0199", score_bcd); end
        gain(1);
        total++;
        if (score_bcd !== 16'h0200) begin bad++; $display("FAIL carry_0200 got=%h exp=0200", score_bcd); end
        for (int blk = 0; blk < 98; blk++) begin
            gain(100);
            total++;
            if (score_bcd !== to_bcd(m_score)) begin
                bad++;
                $display("FAIL score_track got=%h exp=%h", score_bcd, to_bcd(m_score));
            end
        end
        gain(1);
        total++;
        if (score_bcd !== 16'h9999) begin bad++; $display("FAIL score_9999 got=%h exp=9999", score_bcd); end
        gain(1);
        total++;
        if (score_bcd !== 16'h9999 || pass_pulse !== 1'b1) begin
            bad++;
            $display("FAIL saturate score=%h pass=%b exp 9999/1", score_bcd, pass_pulse);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            bx = int'($urandom_range(100, 200));
            by = int'($urandom_range(150, 540));
            for (int i = 0; i < 3; i++) begin
                px[i] = int'($urandom_range(40, 320));
                py[i] = int'($urandom_range(150, 350));
            end
            step($urandom_range(0, 3) == 0);
            total++;
            if (state !== 2'(m_state) || fail !== (m_state == 2) || score_bcd !== to_bcd(m_score) ||
                hiscore_bcd !== to_bcd(m_hi) || hit_pulse !== e_hp || pass_pulse !== e_pp) begin
                bad++;
                $display("FAIL random n=%0d got st=%b f=%b sc=%h hi=%h h=%b p=%b exp st=%0d sc=%h hi=%h h=%b p=%b",
                         n, state, fail, score_bcd, hiscore_bcd, hit_pulse, pass_pulse,
                         m_state, to_bcd(m_score), to_bcd(m_hi), e_hp, e_pp);
            end
        end
    endtask

    task automatic test_hiscore_and_reset();
        logic [15:0] exp_hi;
        do_reset();
        setup_play(240);
        gain(12);
        px[2] = 150; py[2] = 400;
        step(0);
        px[2] = 1000;
        step(1);
        px[0] = 95; px[1] = 95; ph = 1;
        step(1);
        gain(5);
        px[2] = 150;
        step(0);
`ifdef FLAPPY_HISCORE_EN
        exp_hi = 16'h0012;
`else
        exp_hi = 16'h0000;
`endif
        total++;
        if (hiscore_bcd !== exp_hi || hiscore_bcd !== to_bcd(m_hi)) begin
            bad++;
            $display("FAIL hiscore got=%h exp=%h", hiscore_bcd, exp_hi);
        end
        total++;
        if (score_bcd !== 16'h0005) begin bad++; $display("FAIL second_score got=%h exp=0005", score_bcd); end
        px[2] = 1000;
        step(1);
        px[0] = 95; px[1] = 95; ph = 1;
        step(1);
        gain(1);
        cyc(); cyc();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({state, fail, score_bcd, hiscore_bcd, pass_pulse, hit_pulse, audio_out} !== 40'd0) begin
            bad++;
            $display("FAIL midplay_reset got=%h exp=0", {state, fail, score_bcd, hiscore_bcd, pass_pulse, hit_pulse, audio_out});
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        m_state = 0; m_score = 0; m_hi = 0; m_past = '{0, 0, 0};
        s_left = 0; s_k = 0; s_hit = 0; p_hit = 0; p_pass = 0;
        repeat (5) cyc();
    endtask

    initial begin
        test_reset();
        test_start();
        test_pass();
        test_hit();
        test_priority();
        test_random();
        test_saturate();
        test_hiscore_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/flappy_game_core.md
# flappy_game_core

Parametrised game-rule engine for the VGA Flappy Bird design: it takes the bird position and the positions of N pipes, checks collisions and passes once per movement tick, and runs an IDLE/PLAY/DEAD state machine. It keeps a saturating BCD score and an optional high score, and drives a two-tone square-wave audio output. It sits between the block/pipe controllers and the top level, which routes its score to the seven-segment scan logic and its `fail` output to the pixel mux.

## Interface
- `N_PIPES`, 3: number of pipe channels
- `PIPE_HALF_W`, 50: pipe half-width in pixels
- `GAP_HALF`, 50: half-height of the pipe gap
- `BIRD_HALF`, 5: bird hitbox half-size
- `GROUND_Y`, 514: a `bird_y` at or above this value is a ground hit
- `SCORE_DIGITS`, 4: number of BCD digits
- `PASS_DIV`, 83333: pass tone period in clk cycles
- `HIT_DIV`, 166666: hit tone period in clk cycles
- `PASS_DUR`, 5000000: pass sound length in clk cycles
- `HIT_DUR`, 20000000: hit sound length in clk cycles
- `clk` in 1: system clock, 100 MHz
- `rst_n` in 1: asynchronous, active-low reset
- `tick` in 1: one-cycle movement strobe, which replaces the divided move clock
- `start` in 1: start/restart request, level-sampled on `tick`
- `bird_x`, `bird_y` in 12 each: bird centre position
- `pipe_x`, `pipe_y` in 12*N_PIPES each: pipe centre positions, packed; channel i occupies bits [12i+11:12i]
- `state` out 2: 00 IDLE, 01 PLAY, 10 DEAD
- `fail` out 1: high while in DEAD
- `score_bcd` out 4*SCORE_DIGITS: current score, digit 0 in the LSBs
- `hiscore_bcd` out 4*SCORE_DIGITS: best score
- `pass_pulse`, `hit_pulse` out 1 each: one-clk event strobes
- `audio_out` out 1: square-wave audio output

## Operation
- All arithmetic is unsigned at 13 bits. Comparisons are rearranged so that nothing is ever subtracted:
  - x overlap: `bird_x + BIRD_HALF + PIPE_HALF_W >= pipe_x`, and `pipe_x + PIPE_HALF_W + BIRD_HALF >= bird_x`
  - outside gap: `bird_y + GAP_HALF <= pipe_y + BIRD_HALF`, or `bird_y + BIRD_HALF >= pipe_y + GAP_HALF`
- `hit_i` = x overlap AND outside gap. `hit_any` = OR of all `hit_i`, OR `bird_y >= GROUND_Y`.
- `past_i` = `pipe_x + PIPE_HALF_W + BIRD_HALF < bird_x`. The registered copy `past_q[i]` is updated on every tick.
- `pass_i` = `past_i & ~past_q[i]`, a rising edge. This counts exactly once per pipe, even when a pipe wraps around.
- FSM transitions, evaluated only on clk edges where `tick` = 1:
  - IDLE: if `start`, go to PLAY, clear the score, and load `past_q` with the current `past_i`.
  - PLAY: if `hit_any`, go to DEAD and pulse `hit_pulse`. Otherwise, if any `pass_i`, add 1 to the score and pulse `pass_pulse`.
  - DEAD: if `start`, go to IDLE. The score is held in DEAD.
- Hit has priority over pass on the same tick; that tick awards no point.
- Simultaneous passes of several pipes on one tick add 1 in total.
- The score is a BCD ripple increment. It saturates at all 9s and never wraps.
- Audio:
  - A hit starts the hit tone: period `HIT_DIV`, length `HIT_DUR`. It preempts a pass tone that is already playing.
  - A pass starts the pass tone: period `PASS_DIV`, length `PASS_DUR`. It is ignored while the hit tone is active.
  - Each new sound resets the tone counter to 0.
  - `audio_out` = sound active AND `tone_cnt < period/2`.

## Timing
- Reset values: `state` = IDLE, `fail` = 0, `score_bcd` = 0, `hiscore_bcd` = 0, both pulses 0, `audio_out` = 0, `past_q` = 0, duration counter 0, tone counter 0.
- Reset asserted mid-game forces all of the above at once; no sound continues.
- All outputs are registered.
- Inputs are sampled on the clk edge where `tick` = 1.
- `state`, `fail` and `score_bcd` change at that same edge, so their latency is 1 clk.
- `pass_pulse` and `hit_pulse` are high for exactly the 1 clk following that edge.
- The audio sound starts on the clk after the pulse: the duration counter is loaded and `audio_out` goes high. The duration counter then decrements every clk down to 0.
- Between ticks, the core ignores `start` and the geometry inputs.

## Configuration
- `FLAPPY_HISCORE_EN` defined:
  - On the PLAY→DEAD transition, `hiscore_bcd` loads `score_bcd` if the score is greater (BCD compare, most significant digit first).
  - `hiscore_bcd` survives restarts and is cleared only by `rst_n`.
- Not defined: `hiscore_bcd` is tied to 0 and no register is built.

## Test plan
- Reset, then `start` on a tick with `bird_y` = 240 and no pipe overlap → `state` = 01, `score_bcd` = 0, `fail` = 0, `audio_out` = 0.
- In PLAY, bird at (150,240) and pipe0 stepping x from 210 down to 90, gap centre y = 240 → exactly one `pass_pulse` when pipe_x reaches 94; `score_bcd` = 0001; `audio_out` toggles with period 83333 for 5000000 cycles.
- In PLAY, bird at (150,200) with pipe1 x = 150, y = 300 → `hit_pulse`, `state` = 10, `fail` = 1, hit tone active; later ticks leave the score unchanged.
- Same tick gives a pass on pipe0 and a hit on pipe2 → DEAD, score unchanged, only `hit_pulse` asserted.
- Score preloaded to 9999 via passes (`SCORE_DIGITS` = 4), then another pass → score stays 9999; a 0199→0200 carry is checked on the way.
- With `FLAPPY_HISCORE_EN`: die at 0012, restart, die at 0005 → `hiscore_bcd` = 0012. Then assert `rst_n` low mid-play → every output returns to 0 immediately.
